// File: rtl/rr_req_buffer.sv
// Four independent per-channel circular request queues drained by an external
// round-robin arbiter grant; popped entries are delivered one cycle later.
module rr_req_buffer #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned LW   = PW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      in_valid,
  output logic [3:0]      in_ready,
  input  logic [4*DW-1:0] in_data,
  output logic [3:0]      req,
  input  logic [3:0]      grant,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_id,
  output logic [4*LW-1:0] level,
  output logic            grant_err
);

  logic [DW-1:0] r_mem   [4][DEPTH];
  logic [PW-1:0] r_wptr  [4];
  logic [PW-1:0] r_rptr  [4];
  logic [LW-1:0] r_level [4];

  logic [3:0] w_push;
  logic [3:0] w_pop;
  logic       w_multi;
  logic       w_onehot;
  logic [1:0] w_pop_id;

  // Ready/req come from registered occupancy only, so a full queue refuses a
  // push even when it is popped in the same cycle.
  always_comb begin
    w_multi  = (grant & (grant - 4'd1)) != 4'd0;
    w_onehot = (grant != 4'd0) && !w_multi;
    w_pop_id = 2'd0;
    in_ready = 4'd0;
    req      = 4'd0;
    w_push   = 4'd0;
    w_pop    = 4'd0;
    level    = '0;
    for (int i = 0; i < 4; i++) begin
      in_ready[i]           = r_level[i] != LW'(DEPTH);
      req[i]                = r_level[i] != LW'(0);
      w_push[i]             = in_valid[i] && in_ready[i];
      w_pop[i]              = w_onehot && grant[i] && req[i];
      level[i*LW +: LW]     = r_level[i];
      if (grant[i]) w_pop_id = 2'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_wptr[i]  <= '0;
        r_rptr[i]  <= '0;
        r_level[i] <= '0;
      end
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= 2'd0;
      grant_err <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + PW'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PW'(1);
        r_level[i] <= r_level[i] + LW'(w_push[i]) - LW'(w_pop[i]);
      end
      out_valid <= |w_pop;
      if (|w_pop) begin
        out_data <= r_mem[w_pop_id][r_rptr[w_pop_id]];
        out_id   <= w_pop_id;
      end
      grant_err <= grant_err | w_multi;
    end
  end

  // Payload storage is not reset; stale contents are unreachable once levels clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_push[i]) r_mem[i][r_wptr[i]] <= in_data[i*DW +: DW];
    end
  end

endmodule

// File: tb/tb_rr_req_buffer.sv
// Self-checking bench for rr_req_buffer: directed vector table, corner-case
// sequences and a random phase, with a queue-based reference model.
module tb_rr_req_buffer;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int LW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      in_valid;
  logic [3:0]      in_ready;
  logic [4*DW-1:0] in_data;
  logic [3:0]      req;
  logic [3:0]      grant;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_id;
  logic [4*LW-1:0] level;
  logic            grant_err;

  rr_req_buffer #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .req(req), .grant(grant), .out_valid(out_valid),
    .out_data(out_data), .out_id(out_id), .level(level), .grant_err(grant_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_q [4][$];
  logic       m_err;
  logic [9:0] sb_q [$];  // {id, data}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    logic [3:0] e_req, e_rdy;
    for (int i = 0; i < 4; i++) begin
      e_req[i] = m_q[i].size() != 0;
      e_rdy[i] = m_q[i].size() != DEPTH;
      chk($sformatf("%s level%0d", tag, i), 32'(level[i*LW +: LW]), 32'(m_q[i].size()));
    end
    chk({tag, " req"}, 32'(req), 32'(e_req));
    chk({tag, " in_ready"}, 32'(in_ready), 32'(e_rdy));
    chk({tag, " grant_err"}, 32'(grant_err), 32'(m_err));
  endtask

  // Drive one cycle of stimulus, update the model, check after the edge.
  task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic [3:0] g,
                       input string tag);
    logic [3:0] pre_rdy;
    logic [3:0] pre_ne;
    int         pc;
    logic [9:0] exp_out;
    in_valid = v;
    in_data  = d;
    grant    = g;
    pc = -1;
    for (int i = 0; i < 4; i++) begin
      pre_rdy[i] = m_q[i].size() < DEPTH;
      pre_ne[i]  = m_q[i].size() != 0;
    end
    if ($countones(g) == 1) begin
      for (int i = 0; i < 4; i++) if (g[i] && pre_ne[i]) pc = i;
    end
    if ($countones(g) > 1) m_err = 1'b1;
    if (pc >= 0) sb_q.push_back({2'(pc), m_q[pc].pop_front()});
    for (int i = 0; i < 4; i++) if (v[i] && pre_rdy[i]) m_q[i].push_back(d[i*8 +: 8]);
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, 32'(out_valid), 32'(pc >= 0));
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        chk({tag, " unexpected pop"}, 32'(out_valid), 32'd0);
      end else begin
        exp_out = sb_q.pop_front();
        chk({tag, " out_data"}, 32'(out_data), 32'(exp_out[7:0]));
        chk({tag, " out_id"}, 32'(out_id), 32'(exp_out[9:8]));
      end
    end
    chk_state(tag);
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  g;
    logic [3:0]  exp_req;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{4'b0100, 32'h00A1_0000, 4'b0000, 4'b0100, 4'hF, 1'b0, 8'h00};
    vecs[1]  = '{4'b0000, 32'h0,         4'b0100, 4'b0000, 4'hF, 1'b1, 8'hA1};
    vecs[2]  = '{4'b0001, 32'h10,        4'b0000, 4'b0001, 4'hF, 1'b0, 8'hA1};
    vecs[3]  = '{4'b0001, 32'h11,        4'b0000, 4'b0001, 4'hF, 1'b0, 8'hA1};
    vecs[4]  = '{4'b0001, 32'h12,        4'b0000, 4'b0001, 4'hF, 1'b0, 8'hA1};
    vecs[5]  = '{4'b0001, 32'h13,        4'b0000, 4'b0001, 4'hE, 1'b0, 8'hA1};
    vecs[6]  = '{4'b0001, 32'h99,        4'b0000, 4'b0001, 4'hE, 1'b0, 8'hA1};
    vecs[7]  = '{4'b0000, 32'h0,         4'b0001, 4'b0001, 4'hF, 1'b1, 8'h10};
    vecs[8]  = '{4'b0000, 32'h0,         4'b0001, 4'b0001, 4'hF, 1'b1, 8'h11};
    vecs[9]  = '{4'b0000, 32'h0,         4'b0001, 4'b0001, 4'hF, 1'b1, 8'h12};
    vecs[10] = '{4'b0000, 32'h0,         4'b0001, 4'b0000, 4'hF, 1'b1, 8'h13};
    vecs[11] = '{4'b0000, 32'h0,         4'b1000, 4'b0000, 4'hF, 1'b0, 8'h13};

    m_err = 1'b0;
    reset = 1'b1;
    in_valid = 4'd0;
    in_data = '0;
    grant = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst req", 32'(req), 32'h0);
    chk("rst in_ready", 32'(in_ready), 32'hF);
    chk("rst out_valid", 32'(out_valid), 32'h0);
    chk("rst out_data", 32'(out_data), 32'h0);
    chk("rst out_id", 32'(out_id), 32'h0);
    chk("rst grant_err", 32'(grant_err), 32'h0);
    chk("rst level", 32'(level), 32'h0);
    #3 reset = 1'b0;

    // Directed table: hand-derived expectations plus model cross-check.
    for (int k = 0; k < 12; k++) begin
      cycle(vecs[k].v, vecs[k].d, vecs[k].g, $sformatf("vec%0d", k));
      chk($sformatf("vec%0d tbl req", k), 32'(req), 32'(vecs[k].exp_req));
      chk($sformatf("vec%0d tbl rdy", k), 32'(in_ready), 32'(vecs[k].exp_rdy));
      chk($sformatf("vec%0d tbl ov", k), 32'(out_valid), 32'(vecs[k].exp_ov));
      chk($sformatf("vec%0d tbl data", k), 32'(out_data), 32'(vecs[k].exp_data));
    end

    // Full ch1, then push+grant ch1 together: only the pop happens.
    for (int k = 0; k < 4; k++) cycle(4'b0010, 32'(8'h40 + k) << 8, 4'b0000, "fill1");
    cycle(4'b0010, 32'h0000_EE00, 4'b0010, "fullpp");
    chk("fullpp level1", 32'(level[LW +: LW]), 32'd3);
    chk("fullpp data", 32'(out_data), 32'h40);
    for (int k = 0; k < 3; k++) cycle(4'b0000, 32'h0, 4'b0010, "drain1");
    chk("drain1 last", 32'(out_data), 32'h43);

    // Push+pop on empty channel: push only, poppable next cycle.
    cycle(4'b1000, 32'h5A00_0000, 4'b1000, "emptypp");
    chk("emptypp ov", 32'(out_valid), 32'd0);
    cycle(4'b0000, 32'h0, 4'b1000, "emptypp2");
    chk("emptypp2 data", 32'(out_data), 32'h5A);

    // Multi-hot grant: no pop, sticky error.
    cycle(4'b0011, 32'h0000_2221, 4'b0000, "mh_fill");
    cycle(4'b0000, 32'h0, 4'b0011, "mh");
    chk("mh err", 32'(grant_err), 32'd1);
    cycle(4'b0000, 32'h0, 4'b0000, "mh_hold");
    chk("mh err sticky", 32'(grant_err), 32'd1);
    cycle(4'b0000, 32'h0, 4'b0001, "mh_pop0");
    chk("mh_pop0 data", 32'(out_data), 32'h21);

    // Random phase exercises wrap-around and channel independence.
    for (int k = 0; k < 300; k++) begin
      logic [3:0] g;
      g = ($urandom_range(0, 3) == 0) ? 4'd0 : (4'd1 << $urandom_range(0, 3));
      cycle(4'($urandom), $urandom, g, "rnd");
    end

    // Asynchronous reset between edges with ch0 holding 3 entries.
    for (int i = 0; i < 4; i++) while (m_q[i].size() != 0) cycle(4'd0, 32'h0, 4'd1 << i, "flush");
    for (int k = 0; k < 3; k++) cycle(4'b0001, 32'(8'h70 + k), 4'b0000, "pre_ar");
    chk("pre_ar level0", 32'(level[0 +: LW]), 32'd3);
    in_valid = 4'd0;
    grant = 4'd0;
    #2 reset = 1'b1;
    #1;
    chk("ar level0", 32'(level[0 +: LW]), 32'd0);
    chk("ar req", 32'(req), 32'h0);
    chk("ar in_ready", 32'(in_ready), 32'hF);
    chk("ar grant_err", 32'(grant_err), 32'h0);
    chk("ar out_valid", 32'(out_valid), 32'h0);
    for (int i = 0; i < 4; i++) m_q[i].delete();
    sb_q.delete();
    m_err = 1'b0;
    #2 reset = 1'b0;
    cycle(4'b0001, 32'h77, 4'b0000, "post_ar");
    cycle(4'b0000, 32'h0, 4'b0001, "post_ar_pop");
    chk("post_ar data", 32'(out_data), 32'h77);

    chk("sb empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/rr_req_buffer.md
RR_REQ_BUFFER -- requirements
Module: rr_req_buffer

Interface
REQ-001 Parameter: DW, 8, data width of each request payload.
REQ-002 Parameter: DEPTH, 4, entries per channel queue; power of two, minimum 2.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: in_valid  input  4  per-channel push request; bit i belongs to channel i.
REQ-006 Port: in_ready  output  4  per-channel push acceptance; bit i high = queue i not full.
REQ-007 Port: in_data  input  4*DW  channel i payload in bits [i*DW +: DW].
REQ-008 Port: req  output  4  arbiter request vector; bit i high = queue i not empty.
REQ-009 Port: grant  input  4  one-hot grant from the round-robin arbiter.
REQ-010 Port: out_valid  output  1  registered single-cycle pulse marking a popped entry.
REQ-011 Port: out_data  output  DW  payload of the popped entry.
REQ-012 Port: out_id  output  2  channel index of the popped entry.
REQ-013 Port: level  output  4*($clog2(DEPTH)+1)  per-channel occupancy, 0..DEPTH.
REQ-014 Port: grant_err  output  1  sticky flag; set on any multi-hot grant.

Function
REQ-015 The block SHALL contain four independent circular FIFOs, each DEPTH x DW, with a read pointer, a write pointer and an occupancy counter.
REQ-016 A push to channel i SHALL occur on a clock edge where in_valid[i] && in_ready[i]; the payload is written at the write pointer, which then advances modulo DEPTH.
REQ-017 in_ready[i] SHALL equal (level_i != DEPTH), computed from registered state only; a full queue refuses a push even if a pop occurs in the same cycle.
REQ-018 req[i] SHALL equal (level_i != 0), combinational from registered occupancy, zero-latency.
REQ-019 A pop from channel i SHALL occur on a clock edge where grant == (1<<i) and level_i != 0; the read pointer then advances modulo DEPTH.
REQ-020 A grant naming an empty channel SHALL be ignored silently: no pop, no out_valid, no error (stale grant from arbiter latency).
REQ-021 grant == 0 SHALL cause no pop.
REQ-022 Any grant with two or more bits set SHALL cause no pop and SHALL set grant_err, which stays high until reset.
REQ-023 On a pop, the next cycle SHALL show out_valid=1, out_data = popped payload, out_id = i (one-cycle latency); otherwise out_valid=0 and out_data/out_id hold their last values.
REQ-024 Simultaneous push and pop on the same non-full, non-empty channel SHALL both take effect; level unchanged.
REQ-025 Simultaneous push and pop on an empty channel SHALL perform only the push (pop ignored per REQ-020); the pushed entry is poppable from the next cycle.
REQ-026 Pointer wrap-around SHALL be seamless; FIFO order is preserved per channel across wrap.
REQ-027 Channels SHALL be independent; activity on one never alters another's state.
REQ-028 No downstream backpressure exists; every pop is delivered.

Reset
REQ-029 While reset is high, all pointers and levels SHALL be 0, out_valid=0, out_data=0, out_id=0, grant_err=0, hence req=0 and in_ready=4'hF.
REQ-030 Reset asserted mid-operation SHALL discard all queued entries immediately without waiting for a clock edge; payload RAM contents need not be cleared.
REQ-031 First push SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-032 Push 8'hA1 to ch2, then grant=4'b0100 -> req=4'b0100 after push; one cycle after grant, out_valid=1, out_data=8'hA1, out_id=2, req=0.
REQ-033 Push 4 entries 8'h10..8'h13 to ch0 -> level0=4, in_ready[0]=0; 5th push refused; pop 4 -> outputs 10,11,12,13 in order.
REQ-034 Full ch1, push and grant ch1 same cycle -> pop only, level1=3, pushed data not stored.
REQ-035 grant=4'b0011 with ch0/ch1 non-empty -> no pop, levels unchanged, grant_err=1 and remains 1.
REQ-036 Grant to empty ch3 -> out_valid stays 0, grant_err stays 0.
REQ-037 Fill ch0 with 3 entries, assert reset asynchronously between edges -> level0=0, req=0, in_ready=4'hF without a clock edge.
